multi_fifo: RTL
===============

Name: multi_fifo

Overview:
Parametrised synchronous FIFO, successor to the single-entry buffer used on the TTM data paths. It has configurable width and depth and first-word-fall-through (FWFT) reads. It adds almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. It sits between the TDC/event producers and the packetiser/USB-FIFO readers, where a single-entry buffer cannot absorb bursts.

Parameters:
DATA_LENGTH, 32, data word width in bits.
DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (16 by default). Minimum is 1.
ALMOST_FULL_TH, 12, almost_full_o asserted when level >= this value. Range 1..DEPTH.
ALMOST_EMPTY_TH, 2, almost_empty_o asserted when level <= this value. Range 0..DEPTH-1.

Ports:
clk  in  1  system clock, 100 MHz
rstn  in  1  asynchronous reset, active low
clear_i  in  1  synchronous flush; empties FIFO and clears error flags
fifo_data_i  in  DATA_LENGTH  write data
write_i  in  1  write request
full_o  out  1  level == DEPTH
almost_full_o  out  1  level >= ALMOST_FULL_TH
fifo_data_o  out  DATA_LENGTH  head word (FWFT); valid only while empty_o=0
read_i  in  1  read/pop request
empty_o  out  1  level == 0
almost_empty_o  out  1  level <= ALMOST_EMPTY_TH
level_o  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
overflow_o  out  1  sticky: a write was dropped
underflow_o  out  1  sticky: a read was issued while empty

Behaviour:
- Single clock domain, clk. rstn is asynchronous and active low.
- Values while rstn is low:
  - wr_ptr = 0, rd_ptr = 0, level = 0.
  - empty_o = 1, full_o = 0.
  - almost_empty_o = 1; almost_full_o = 0 (guaranteed because ALMOST_FULL_TH >= 1).
  - overflow_o = 0, underflow_o = 0.
  - fifo_data_o is X. The memory array is not reset.
- All status outputs are registered and reflect the post-update level on the same edge that changes it. No combinational path exists from inputs to status outputs.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH naturally. level is DEPTH_LOG2+1 bits so that the value DEPTH is representable.
- fifo_data_o is a combinational read of mem[rd_ptr] (FWFT).
  - A write into an empty FIFO at edge N makes the data visible, with empty_o=0, in the cycle after edge N. Write-to-read latency is 1 cycle.
  - Popping at edge N presents the next word in the cycle after edge N.
- Accepted write: write_i & (~full_o | read_i). Stores fifo_data_i at mem[wr_ptr], then wr_ptr+1.
- Accepted read: read_i & ~empty_o. rd_ptr+1.
- Priority per clock edge, highest first:
  1. clear_i=1: pointers, level and sticky flags go to their reset values; write_i and read_i are ignored that cycle; memory contents are unchanged.
  2. Otherwise the accept rules below apply.
- Accept rules by condition:
  - Write and read, not full and not empty: both accepted; level unchanged.
  - Write and read, full: read and write both accepted; level stays DEPTH; full_o stays 1.
  - Write and read, empty: write accepted; read ignored; underflow_o is set; level becomes 1.
  - Write only, full: data dropped; overflow_o is set; state otherwise unchanged.
  - Read only, empty: underflow_o is set; state unchanged.
- overflow_o and underflow_o stay set until clear_i or rstn.
- Reset asserted mid-burst drops all contents immediately; no partial write completes.
- A DEPTH_LOG2=0 instance is not supported; one_fifo covers depth 1.

Decomposition:
- Shared include/package, fifo_pkg:
  - function clog2.
  - localparam DEPTH derivation.
  - status-bit index constants (FULL, AFULL, EMPTY, AEMPTY, OVF, UNF) for register-map packing.
- One sub-module, fifo_dp_ram:
  - DEPTH x DATA_LENGTH array.
  - One synchronous write port and one asynchronous read port.
  - No reset; infers distributed RAM.
- Pointer, level and flag logic stays in multi_fifo.

Test Plan:
1. Reset, then write 0x00000001..0x00000010 on consecutive cycles (16 writes):
   - full_o=1 and level_o=16 after the 16th edge.
   - almost_full_o rises at the edge where level becomes 12.
   - empty_o falls 1 cycle after the first write.
2. From full, read 16 times:
   - fifo_data_o sequence is 0x1..0x10 (FWFT, no bubble).
   - empty_o=1 after the last read.
   - almost_empty_o rises when level becomes 2.
3. Simultaneous write and read for 40 cycles at level 16, then at level 5:
   - level_o holds 16, then 5.
   - Output order is preserved across pointer wrap.
   - overflow_o=0 throughout.
4. Write while full with read_i=0, data 0xDEADBEEF:
   - overflow_o=1, level_o=16.
   - 0xDEADBEEF never appears on fifo_data_o.
   - Read while empty sets underflow_o=1 and level_o stays 0.
5. At level 7, pulse clear_i together with write_i=1 and read_i=1:
   - The next cycle shows level_o=0, empty_o=1, almost_empty_o=1, overflow_o=0, underflow_o=0.
   - The write is discarded.
6. At level 9, assert rstn=0 asynchronously mid-cycle:
   - empty_o=1, level_o=0 and flags cleared before the next clk edge.
   - After release, the first write 0xA5A5A5A5 appears on fifo_data_o 1 cycle later.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers and constants for the multi_fifo slice.
// Status-bit indices double as the register-map packing order.
package fifo_pkg;

    localparam int FULL     = 0;
    localparam int AFULL    = 1;
    localparam int EMPTY    = 2;
    localparam int AEMPTY   = 3;
    localparam int OVF      = 4;
    localparam int UNF      = 5;
    localparam int STATUS_W = 6;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Storage for multi_fifo: one synchronous write port,
// one asynchronous read port, no reset (distributed RAM).
module fifo_dp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_LENGTH = 32,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_LENGTH-1:0] wdata,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [DATA_LENGTH-1:0] rdata
);

    logic [DATA_LENGTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/multi_fifo.sv
// Parametrised FWFT FIFO with thresholds, occupancy count,
// sticky overflow/underflow flags and synchronous flush.
module multi_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_LENGTH     = 32,
    parameter int DEPTH_LOG2      = 4,
    parameter int ALMOST_FULL_TH  = 12,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear_i,
    input  logic [DATA_LENGTH-1:0] fifo_data_i,
    input  logic                   write_i,
    output logic                   full_o,
    output logic                   almost_full_o,
    output logic [DATA_LENGTH-1:0] fifo_data_o,
    input  logic                   read_i,
    output logic                   empty_o,
    output logic                   almost_empty_o,
    output logic [DEPTH_LOG2:0]    level_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG2);
    localparam int PW    = DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic [LW-1:0]       level_nxt;
    logic [STATUS_W-1:0] status;
    logic [STATUS_W-1:0] status_nxt;
    logic                wr_en;
    logic                rd_en;
    logic                ram_we;

    // A full FIFO still takes a write when a pop frees the slot
    assign wr_en  = write_i & (~status[FULL] | read_i);
    assign rd_en  = read_i & ~status[EMPTY];
    assign ram_we = wr_en & ~clear_i & rstn;

    always_comb begin
        level_nxt = level;
        if (wr_en & ~rd_en) begin
            level_nxt = level + LW'(1);
        end else if (rd_en & ~wr_en) begin
            level_nxt = level - LW'(1);
        end
    end

    always_comb begin
        status_nxt         = '0;
        status_nxt[FULL]   = level_nxt == LW'(DEPTH);
        status_nxt[AFULL]  = int'(level_nxt) >= ALMOST_FULL_TH;
        status_nxt[EMPTY]  = level_nxt == '0;
        status_nxt[AEMPTY] = int'(level_nxt) <= ALMOST_EMPTY_TH;
        status_nxt[OVF]    = status[OVF] | (write_i & ~wr_en);
        status_nxt[UNF]    = status[UNF] | (read_i & status[EMPTY]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            status         <= '0;
            status[EMPTY]  <= 1'b1;
            status[AEMPTY] <= 1'b1;
        end else if (clear_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            status         <= '0;
            status[EMPTY]  <= 1'b1;
            status[AEMPTY] <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level  <= level_nxt;
            status <= status_nxt;
        end
    end

    fifo_dp_ram #(
        .DATA_LENGTH(DATA_LENGTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wr_ptr),
        .wdata(fifo_data_i),
        .raddr(rd_ptr),
        .rdata(fifo_data_o)
    );

    assign full_o         = status[FULL];
    assign almost_full_o  = status[AFULL];
    assign empty_o        = status[EMPTY];
    assign almost_empty_o = status[AEMPTY];
    assign overflow_o     = status[OVF];
    assign underflow_o    = status[UNF];
    assign level_o        = level;

endmodule
